uart_rx_to_bus: RTL and testbench
=================================

# uart_rx_to_bus

Receive-direction counterpart of the bus-to-UART transmit path. Deserialises 8N1 UART frames from the external line, buffers received bytes in a small FIFO, and returns them to a bus master as a bit-serial read response. Sits between the external RX pin and the system bus, as a bus slave.

## Interface

- CLKS_PER_BIT, 20, clk cycles per UART bit; even, ≥ 4
- N, 8, data bits per frame and per bus response
- FIFO_DEPTH, 4, received-byte buffer entries; power of two
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- rx_external  in  1  UART serial input; idle high
- validIn  in  1  bus request strobe
- wren  in  1  1 = write, ignored; 0 = read
- ready  out  1  high when a read would be accepted
- validOut  out  1  high while DataOut carries response bits
- DataOut  out  1  serial read data, LSB first
- rx_busy  out  1  high while a frame is being received
- overrun  out  1  sticky; set when a byte is dropped on full FIFO; cleared only by reset
- frame_err  out  1  one-cycle pulse on a bad stop bit
- state_out  out  4  [1:0] RX state, [2] bus shifting, [3] FIFO full

## Operation

- rx_external passes through a 2-flop synchroniser, reset to 1; all RX logic uses the synchronised value.
- RX FSM, encoded IDLE=0, START=1, DATA=2, STOP=3:
  - IDLE: a synchronised 0 goes to START and loads the bit counter.
  - START: waits CLKS_PER_BIT/2 cycles, then samples. 0 goes to DATA; 1 is a glitch and returns to IDLE with no side effects.
  - DATA: samples every CLKS_PER_BIT cycles, N samples, shifted in LSB first, then STOP.
  - STOP: samples after CLKS_PER_BIT.
    - 1: push the byte, or if full drop it and set overrun; return to IDLE.
    - 0: drop the byte, pulse frame_err, return to IDLE.
- rx_busy = (RX state != IDLE).
- FIFO: circular, log2(FIFO_DEPTH)+1-bit pointers, full/empty from the pointer MSB comparison.
  - Push and pop in the same cycle while full: both succeed; no overrun.
- Bus FSM, B_IDLE / B_SHIFT:
  - ready = B_IDLE && !empty.
  - validIn && !wren && ready pops the head byte into the shift register and enters B_SHIFT.
  - B_SHIFT drives validOut=1 with DataOut = bit k for N consecutive cycles, k = 0..N-1, then returns to B_IDLE with DataOut=0.
  - A read while ready=0 is ignored; the master retries.
  - Writes (validIn && wren) are ignored in every state.

## Timing

- Reset values: ready=0, validOut=0, DataOut=0, rx_busy=0, overrun=0, frame_err=0, state_out=0. FIFO empty, both FSMs idle.
- Line-to-FSM latency: 2 cycles through the synchroniser.
- Start sample is taken CLKS_PER_BIT/2 cycles after the START transition. Each data sample and the stop sample follow at CLKS_PER_BIT-cycle spacing.
- A byte pushed at the stop-sample edge makes ready=1 on the next cycle, provided the bus FSM is in B_IDLE.
- A read accepted at edge t drives validOut=1 and DataOut=bit0 from t+1. The last bit is at t+N, and validOut=0 at t+N+1.
- A back-to-back read is accepted no earlier than the B_IDLE cycle after a response.
- A falling edge seen during STOP is not acted on until the FSM is back in IDLE.
- Reset asserted mid-frame or mid-response aborts immediately. The partial byte is discarded and the outputs return to their reset values asynchronously.

## Configuration

- UART_RX_PARITY_EN defined:
  - An even-parity bit is expected between the last data bit and the stop bit.
  - A parity mismatch drops the byte and pulses frame_err, like a bad stop bit.
  - The RX FSM gains a PARITY state, and state_out[1:0] widens to a 3-bit internal encoding reported modulo 4.
- Not defined: plain 8N1, no PARITY state.

## Test plan

- 0x55 sent at CLKS_PER_BIT=20, then a read → ready=1 one cycle after the stop sample; validOut high for 8 cycles; DataOut 1,0,1,0,1,0,1,0.
- 5-cycle low glitch on an idle line → RX FSM returns to IDLE; no push; ready stays 0.
- Frame 0xA3 with stop bit = 0 → frame_err pulses for 1 cycle; FIFO stays empty.
- Five frames 0x01..0x05 with no reads, FIFO_DEPTH=4 → overrun=1; four reads return 0x01..0x04; ready=0 afterwards.
- Read with FIFO empty, then a write while a byte is buffered → both ignored; validOut stays 0; FIFO count unchanged.
- Reset asserted during the DATA state of 0xFF → all outputs 0 at once; after release, a clean 0x3C frame is received and read correctly.

Source files
------------

// File: rtl/uart_rx_to_bus.sv
// UART 8N1 receiver with a byte FIFO, drained as a bit-serial bus read response.
// Define UART_RX_PARITY_EN to expect an even-parity bit before the stop bit.
module uart_rx_to_bus #(
    parameter int CLKS_PER_BIT = 20,
    parameter int N            = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_external,
    input  logic       validIn,
    input  logic       wren,
    output logic       ready,
    output logic       validOut,
    output logic       DataOut,
    output logic       rx_busy,
    output logic       overrun,
    output logic       frame_err,
    output logic [3:0] state_out
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(N + 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3, PARITY = 3'd4
    } rx_state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3
    } rx_state_t;
`endif
    typedef enum logic {B_IDLE, B_SHIFT} bus_state_t;

    logic          sync1, sync2;
    rx_state_t     rx_q, rx_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [IW-1:0] idx_q, idx_n;
    logic [N-1:0]  sh_q, sh_n;
    logic          push, ferr;

    logic [N-1:0]  mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          empty, full, pop, do_push;

    bus_state_t    bus_q, bus_n;
    logic [IW-1:0] bcnt_q, bcnt_n;
    logic [N-1:0]  bsh_q, bsh_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rx_external;
            sync2 <= sync1;
        end
    end

    always_comb begin
        rx_n  = rx_q;
        cnt_n = cnt_q;
        idx_n = idx_q;
        sh_n  = sh_q;
        push  = 1'b0;
        ferr  = 1'b0;
        unique case (rx_q)
            IDLE: begin
                if (!sync2) begin
                    rx_n  = START;
                    cnt_n = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_END) begin
                    cnt_n = '0;
                    idx_n = '0;
                    rx_n  = sync2 ? IDLE : DATA;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_n = '0;
                    sh_n  = {sync2, sh_q[N-1:1]};
                    if (idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                        rx_n = PARITY;
`else
                        rx_n = STOP;
`endif
                    end else begin
                        idx_n = idx_q + 1'b1;
                    end
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == BIT_END) begin
                    cnt_n = '0;
                    if (sync2 != ^sh_q) begin
                        ferr = 1'b1;
                        rx_n = IDLE;
                    end else begin
                        rx_n = STOP;
                    end
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (cnt_q == BIT_END) begin
                    cnt_n = '0;
                    rx_n  = IDLE;
                    push  = sync2;
                    ferr  = !sync2;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            default: rx_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_q      <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            sh_q      <= '0;
            frame_err <= 1'b0;
        end else begin
            rx_q      <= rx_n;
            cnt_q     <= cnt_n;
            idx_q     <= idx_n;
            sh_q      <= sh_n;
            frame_err <= ferr;
        end
    end

    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign ready   = (bus_q == B_IDLE) && !empty;
    assign pop     = validIn && !wren && ready;
    assign do_push = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= sh_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !do_push) overrun <= 1'b1;
        end
    end

    always_comb begin
        bus_n  = bus_q;
        bcnt_n = bcnt_q;
        bsh_n  = bsh_q;
        unique case (bus_q)
            B_IDLE: begin
                if (pop) begin
                    bus_n  = B_SHIFT;
                    bcnt_n = '0;
                    bsh_n  = mem[rd_ptr[AW-1:0]];
                end
            end
            B_SHIFT: begin
                bsh_n = bsh_q >> 1;
                if (bcnt_q == LAST_IDX) bus_n = B_IDLE;
                else bcnt_n = bcnt_q + 1'b1;
            end
            default: bus_n = B_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_q  <= B_IDLE;
            bcnt_q <= '0;
            bsh_q  <= '0;
        end else begin
            bus_q  <= bus_n;
            bcnt_q <= bcnt_n;
            bsh_q  <= bsh_n;
        end
    end

    assign validOut  = (bus_q == B_SHIFT);
    assign DataOut   = validOut & bsh_q[0];
    assign rx_busy   = (rx_q != IDLE);
    assign state_out = {full, validOut, rx_q[1:0]};

endmodule

// File: tb/tb_uart_rx_to_bus.sv
// Scoreboard bench for uart_rx_to_bus: serial frames in, bus reads out.
// Expected bytes are queued at frame send time and compared at read time.
module tb_uart_rx_to_bus;
    localparam int CPB   = 20;
    localparam int NB    = 8;
    localparam int DEPTH = 4;
    localparam int GAP   = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_external;
    logic       validIn;
    logic       wren;
    logic       ready;
    logic       validOut;
    logic       DataOut;
    logic       rx_busy;
    logic       overrun;
    logic       frame_err;
    logic [3:0] state_out;

    int n_chk  = 0;
    int n_pass = 0;
    logic [7:0] exp_q[$];
    logic       model_ovf = 1'b0;

    uart_rx_to_bus #(
        .CLKS_PER_BIT(CPB),
        .N(NB),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_external(rx_external),
        .validIn(validIn),
        .wren(wren),
        .ready(ready),
        .validOut(validOut),
        .DataOut(DataOut),
        .rx_busy(rx_busy),
        .overrun(overrun),
        .frame_err(frame_err),
        .state_out(state_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Drives one frame from a negedge; index n counts negedges from the start bit.
    task automatic send_frame(input logic [7:0] b, input logic stop,
                              output int rdy_at, output int ferr_n,
                              output logic busy_mid, output logic [3:0] st_mid);
        logic [9:0] bits;
        logic       prev;
        bits   = {stop, b, 1'b0};
        rdy_at = -1;
        ferr_n = 0;
        busy_mid = 1'b0;
        st_mid = '0;
        prev = 1'b1;
        for (int n = 0; n < 10 * CPB + GAP; n++) begin
            @(negedge clk);
            if (n == 0) prev = ready;
            if (ready && !prev && rdy_at < 0) rdy_at = n;
            prev = ready;
            if (frame_err) ferr_n++;
            if (n == 100) begin
                busy_mid = rx_busy;
                st_mid   = state_out;
            end
            rx_external = (n < 10 * CPB) ? bits[n / CPB] : 1'b1;
        end
    endtask

    task automatic send_good(input logic [7:0] b);
        int r, f;
        logic bm;
        logic [3:0] sm;
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else model_ovf = 1'b1;
        send_frame(b, 1'b1, r, f, bm, sm);
    endtask

    task automatic read_check(input string tag);
        logic [7:0] got;
        logic [7:0] exp;
        int vcnt;
        int w;
        got  = '0;
        vcnt = 0;
        w    = 0;
        while (!ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_ready"}, ready, 1'b1);
        if (ready) begin
            validIn = 1'b1;
            wren    = 1'b0;
            @(negedge clk);
            validIn = 1'b0;
            for (int k = 0; k < NB; k++) begin
                if (k > 0) @(negedge clk);
                got[k] = DataOut;
                if (validOut) vcnt++;
            end
            @(negedge clk);
            check({tag, "_vcnt"}, vcnt, NB);
            check({tag, "_vend"}, {validOut, DataOut}, 2'b00);
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            check({tag, "_data"}, got, exp);
        end
    endtask

    initial begin
        int rdy_at, ferr_n, vo;
        logic bm;
        logic [3:0] sm;

        reset = 1'b1;
        rx_external = 1'b1;
        validIn = 1'b0;
        wren = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outs",
              {ready, validOut, DataOut, rx_busy, overrun, frame_err},
              6'b0);
        check("rst_state", state_out, 4'h0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // 0x55 with latency and mid-frame state checks
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, rdy_at, ferr_n, bm, sm);
        check("t1_rdy_at", rdy_at, 193);
        check("t1_busy_mid", bm, 1'b1);
        check("t1_state_mid", sm, 4'h2);
        check("t1_ferr", ferr_n, 0);
        read_check("t1");

        // Short low glitch on idle line
        @(negedge clk);
        rx_external = 1'b0;
        repeat (5) @(negedge clk);
        rx_external = 1'b1;
        check("t2_busy_start", rx_busy, 1'b1);
        repeat (30) @(negedge clk);
        check("t2_idle", {rx_busy, ready, state_out}, 6'b0);

        // Bad stop bit
        send_frame(8'hA3, 1'b0, rdy_at, ferr_n, bm, sm);
        check("t3_ferr_pulses", ferr_n, 1);
        check("t3_empty", ready, 1'b0);

        // Overflow of the buffer
        for (int i = 1; i <= 5; i++) send_good(8'(i));
        check("t4_overrun", overrun, model_ovf);
        check("t4_full", state_out[3], 1'b1);
        for (int i = 0; i < DEPTH; i++) read_check("t4");
        repeat (2) @(negedge clk);
        check("t4_drained", ready, 1'b0);

        // Ignored read on empty FIFO, ignored write on a buffered byte
        vo = 0;
        validIn = 1'b1;
        wren = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (validOut) vo++;
        end
        validIn = 1'b0;
        check("t5_empty_read", vo, 0);
        send_good(8'h5A);
        vo = 0;
        validIn = 1'b1;
        wren = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (validOut) vo++;
        end
        validIn = 1'b0;
        wren = 1'b0;
        check("t5_write_vout", vo, 0);
        check("t5_still_ready", ready, 1'b1);
        read_check("t5");
        @(negedge clk);
        check("t5_one_entry", ready, 1'b0);

        // Asynchronous reset in the middle of an 0xFF frame
        rx_external = 1'b0;
        repeat (CPB) @(negedge clk);
        rx_external = 1'b1;
        repeat (45) @(negedge clk);
        check("t6_pre", {rx_busy, overrun, state_out[1:0]}, 4'b1110);
        #1 reset = 1'b1;
        #1;
        check("t6_async_outs",
              {ready, validOut, DataOut, rx_busy, overrun, frame_err},
              6'b0);
        check("t6_async_state", state_out, 4'h0);
        exp_q.delete();
        model_ovf = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (CPB * 8) @(negedge clk);
        check("t6_idle_after", {rx_busy, ready}, 2'b00);
        send_good(8'h3C);
        read_check("t6");
        check("t6_overrun", overrun, model_ovf);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
